// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester ports (A = CPU memory path, B = loader/debug path)
// and the single-port RAM bus that mem_port_arbiter sits between.
//   a_req/a_we/a_addr/a_wdata -> arbiter   : port A request and payload
//   a_ack/a_rdata             <- arbiter   : port A completion pulse and data
//   b_*                                    : same set for port B
//   mem_en/mem_we/mem_addr/mem_wdata <- arbiter : RAM strobe, write enable,
//                                                 address, write data
//   mem_rdata                 -> arbiter   : RAM read data
//   busy/grant_b              <- arbiter   : sequencer status, last grant
// Modport slave is the arbiter's view; master is the requesters-plus-RAM view.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant_b;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, grant_b
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, grant_b
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter and transaction sequencer for the single-port RAM behind
// MAR/MDR. One requester at a time is granted; its request is captured, issued
// to the RAM for one cycle, the read latency is waited out, read data is
// captured into that port's rdata register and a one-cycle ack is returned.
//
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous, active-high reset
//   bus    : mem_port_arbiter_if.slave -- requester ports A/B, RAM bus,
//            busy and grant_b status (all outputs registered)
//
// Parameters:
//   ADDR_W   : RAM address width
//   DATA_W   : data width
//   READ_LAT : cycles from the mem_en edge to valid mem_rdata (1..4)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mem_port_arbiter_if.slave    bus
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // Captured transaction and sequencing state
    logic                r_grant_b;     // doubles as last_grant (1 = B)
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;

    // Registered outputs
    logic                r_mem_en;
    logic                r_mem_we;
    logic                r_a_ack;
    logic                r_b_ack;
    logic                r_busy;
    logic [DATA_W-1:0]   r_a_rdata;
    logic [DATA_W-1:0]   r_b_rdata;

    // Arbitration result for the current IDLE cycle
    logic                w_grant;
    logic                w_sel_b;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_sel_b     = r_grant_b;
        case (r_state)
            S_IDLE: begin
                if (bus.a_req && bus.b_req) begin
                    // Tie goes to whoever was not granted last time
                    w_grant = 1'b1;
                    w_sel_b = ~r_grant_b;
                end else if (bus.a_req) begin
                    w_grant = 1'b1;
                    w_sel_b = 1'b0;
                end else if (bus.b_req) begin
                    w_grant = 1'b1;
                    w_sel_b = 1'b1;
                end
                if (w_grant) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_we || (READ_LAT == 1)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 3'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_sel_we    = w_sel_b ? bus.b_we    : bus.a_we;
        w_sel_addr  = w_sel_b ? bus.b_addr  : bus.a_addr;
        w_sel_wdata = w_sel_b ? bus.b_wdata : bus.a_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_grant_b <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_busy    <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_state <= w_next;

            // Payload is frozen at the grant edge; later input changes are ignored
            if (w_grant) begin
                r_grant_b <= w_sel_b;
                r_we      <= w_sel_we;
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
            end

            // Loaded during ISSUE so WAIT sees READ_LAT-1 on its first cycle
            if (r_state == S_ISSUE) begin
                r_cnt <= CNT_W'(READ_LAT - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end

            // Outputs are decoded from the next state so they line up with it
            r_mem_en <= (w_next == S_ISSUE);
            r_mem_we <= (w_next == S_ISSUE) && w_sel_we;
            r_busy   <= (w_next != S_IDLE);
            r_a_ack  <= (w_next == S_DONE) && !r_grant_b;
            r_b_ack  <= (w_next == S_DONE) &&  r_grant_b;

            // RAM data is valid on the edge that enters DONE
            if ((w_next == S_DONE) && !r_we) begin
                if (r_grant_b) begin
                    r_b_rdata <= bus.mem_rdata;
                end else begin
                    r_a_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.a_ack     = r_a_ack;
    assign bus.b_ack     = r_b_ack;
    assign bus.a_rdata   = r_a_rdata;
    assign bus.b_rdata   = r_b_rdata;
    assign bus.busy      = r_busy;
    assign bus.grant_b   = r_grant_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiter instances share clock and reset: index 0 has READ_LAT=1, index 1
// has READ_LAT=3. Each has its own RAM model and its own requester stimulus.
// A transaction-level model predicts every output each cycle from the grant
// cycle, the transaction length and a model memory.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam logic [DW-1:0] JUNK = 32'hBAD0_D00D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Requester drive, one slot per instance
    logic          a_req_v [2];
    logic          a_we_v  [2];
    logic [AW-1:0] a_addr_v[2];
    logic [DW-1:0] a_wd_v  [2];
    logic          b_req_v [2];
    logic          b_we_v  [2];
    logic [AW-1:0] b_addr_v[2];
    logic [DW-1:0] b_wd_v  [2];

    // Observed outputs
    logic          a_ack_o[2], b_ack_o[2], en_o[2], we_o[2], busy_o[2], gb_o[2];
    logic [AW-1:0] maddr_o[2];
    logic [DW-1:0] mwd_o[2], ard_o[2], brd_o[2], ram1ff_o[2];

    // RAM preload port
    logic          pl_en[2];
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (ifc)
        );

        assign ifc.a_req   = a_req_v[g];
        assign ifc.a_we    = a_we_v[g];
        assign ifc.a_addr  = a_addr_v[g];
        assign ifc.a_wdata = a_wd_v[g];
        assign ifc.b_req   = b_req_v[g];
        assign ifc.b_we    = b_we_v[g];
        assign ifc.b_addr  = b_addr_v[g];
        assign ifc.b_wdata = b_wd_v[g];

        assign a_ack_o[g] = ifc.a_ack;
        assign b_ack_o[g] = ifc.b_ack;
        assign en_o[g]    = ifc.mem_en;
        assign we_o[g]    = ifc.mem_we;
        assign busy_o[g]  = ifc.busy;
        assign gb_o[g]    = ifc.grant_b;
        assign maddr_o[g] = ifc.mem_addr;
        assign mwd_o[g]   = ifc.mem_wdata;
        assign ard_o[g]   = ifc.a_rdata;
        assign brd_o[g]   = ifc.b_rdata;

        // RAM: data for an access launched with mem_en is readable LAT cycles
        // after the edge that raised mem_en; junk otherwise.
        logic [DW-1:0] ram [512];
        logic [DW-1:0] pipe[3];
        logic [DW-1:0] rd_now;

        always_comb rd_now = (ifc.mem_en && !ifc.mem_we) ? ram[ifc.mem_addr] : JUNK;

        always @(posedge clk) begin
            if (pl_en[g]) ram[pl_addr] <= pl_data;
            if (ifc.mem_en && ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
            pipe[0] <= rd_now;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        assign ifc.mem_rdata = (LAT == 1) ? rd_now : pipe[(LAT >= 2) ? LAT - 2 : 0];
        assign ram1ff_o[g]   = ram[9'h1FF];
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit            m_act  [2];
    int            m_start[2];
    int            m_len  [2];
    bit            m_b    [2];
    bit            m_we   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd   [2];
    logic [DW-1:0] m_ard  [2];
    logic [DW-1:0] m_brd  [2];
    logic [DW-1:0] m_mem  [2][512];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int k;
            bit e_busy, e_en, e_we, e_aa, e_ba;
            if (rst) begin
                m_act[d] = 1'b0;
                m_b[d]   = 1'b1;
                m_ard[d] = '0;
                m_brd[d] = '0;
            end
            k = m_act[d] ? (cyc - m_start[d]) : -1;
            if (m_act[d] && k > m_len[d]) begin
                m_act[d] = 1'b0;
                k = -1;
            end
            if (m_act[d] && k == 1 && m_we[d]) m_mem[d][m_addr[d]] = m_wd[d];
            if (m_act[d] && k == m_len[d] && !m_we[d]) begin
                if (m_b[d]) m_brd[d] = m_mem[d][m_addr[d]];
                else        m_ard[d] = m_mem[d][m_addr[d]];
            end
            e_busy = m_act[d] && k >= 1;
            e_en   = m_act[d] && k == 1;
            e_we   = e_en && m_we[d];
            e_aa   = m_act[d] && k == m_len[d] && !m_b[d];
            e_ba   = m_act[d] && k == m_len[d] &&  m_b[d];
            chk($sformatf("ctrl{busy,en,we,aack,back,gb}_d%0d", d),
                {busy_o[d], en_o[d], we_o[d], a_ack_o[d], b_ack_o[d], gb_o[d]},
                {e_busy, e_en, e_we, e_aa, e_ba, m_b[d]});
            if (e_en) begin
                chk($sformatf("mem_addr_d%0d", d), maddr_o[d], m_addr[d]);
                if (m_we[d]) chk($sformatf("mem_wdata_d%0d", d), mwd_o[d], m_wd[d]);
            end
            if (rst) begin
                chk($sformatf("rst_addr_d%0d", d), maddr_o[d], 0);
                chk($sformatf("rst_wdata_d%0d", d), mwd_o[d], 0);
            end
            chk($sformatf("a_rdata_d%0d", d), ard_o[d], m_ard[d]);
            chk($sformatf("b_rdata_d%0d", d), brd_o[d], m_brd[d]);
            if (!rst && !m_act[d] && (a_req_v[d] || b_req_v[d])) begin
                m_b[d]     = (a_req_v[d] && b_req_v[d]) ? !m_b[d] : b_req_v[d];
                m_we[d]    = m_b[d] ? b_we_v[d]   : a_we_v[d];
                m_addr[d]  = m_b[d] ? b_addr_v[d] : a_addr_v[d];
                m_wd[d]    = m_b[d] ? b_wd_v[d]   : a_wd_v[d];
                m_start[d] = cyc;
                m_len[d]   = m_we[d] ? 2 : lat_of(d) + 1;
                m_act[d]   = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input int d, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(posedge clk); #1;
        pl_en[d] = 1'b1;
        pl_addr  = addr;
        pl_data  = data;
        m_mem[d][addr] = data;
        @(posedge clk); #1;
        pl_en[d] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One transaction on instance d; offsets are counted from the IDLE cycle
    // in which the request is first sampled (offset 0).
    task automatic txn(input int d, input bit port, input bit we,
                       input logic [AW-1:0] addr, input logic [AW-1:0] addr_late,
                       input logic [DW-1:0] wd,
                       output int en_c, output int ack_c, output int wait_c,
                       output bit other);
        en_c = -1; ack_c = -1; wait_c = 0; other = 1'b0;
        @(posedge clk); #1;
        if (port) begin
            b_req_v[d] = 1'b1; b_we_v[d] = we; b_addr_v[d] = addr; b_wd_v[d] = wd;
        end else begin
            a_req_v[d] = 1'b1; a_we_v[d] = we; a_addr_v[d] = addr; a_wd_v[d] = wd;
        end
        for (int n = 0; n < 20 && ack_c < 0; n++) begin
            @(negedge clk);
            if (en_o[d] && en_c < 0) en_c = n;
            if (busy_o[d] && !en_o[d] && !a_ack_o[d] && !b_ack_o[d]) wait_c++;
            if (port ? a_ack_o[d] : b_ack_o[d]) other = 1'b1;
            if (port ? b_ack_o[d] : a_ack_o[d]) ack_c = n;
            if (n == 2) begin
                if (port) b_addr_v[d] = addr_late;
                else      a_addr_v[d] = addr_late;
            end
        end
        @(posedge clk); #1;
        a_req_v[d] = 1'b0;
        b_req_v[d] = 1'b0;
    endtask

    task automatic chk_rst_now(input int d);
        chk("rst_now_ctrl", {busy_o[d], en_o[d], we_o[d], a_ack_o[d], b_ack_o[d]}, 0);
        chk("rst_now_grant_b", gb_o[d], 1);
        chk("rst_now_addr", maddr_o[d], 0);
        chk("rst_now_wdata", mwd_o[d], 0);
        chk("rst_now_a_rdata", ard_o[d], 0);
        chk("rst_now_b_rdata", brd_o[d], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_c, ack_c, wait_c;
        bit other;
        int acks_seen;
        bit ord_q[$];
        logic [5:0] exp_ord;

        for (int d = 0; d < 2; d++) begin
            a_req_v[d] = 0; a_we_v[d] = 0; a_addr_v[d] = '0; a_wd_v[d] = '0;
            b_req_v[d] = 0; b_we_v[d] = 0; b_addr_v[d] = '0; b_wd_v[d] = '0;
            pl_en[d] = 0;
        end
        pl_addr = '0;
        pl_data = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("init_grant_b", gb_o[0], 1);
        chk("init_busy", busy_o[0], 0);

        // READ_LAT=1: A read of a preloaded word
        preload(0, 9'h010, 32'hDEADBEEF);
        txn(0, 1'b0, 1'b0, 9'h010, 9'h010, '0, en_c, ack_c, wait_c, other);
        chk("t1_en_cycle", en_c, 1);
        chk("t1_ack_cycle", ack_c, 2);
        chk("t1_a_rdata", ard_o[0], 32'hDEADBEEF);
        chk("t1_b_ack_seen", other, 0);

        // B writes, then A reads the same word back
        txn(0, 1'b1, 1'b1, 9'h1FF, 9'h1FF, 32'h12345678, en_c, ack_c, wait_c, other);
        chk("t2_write_ack_cycle", ack_c, 2);
        chk("t2_ram_1ff", ram1ff_o[0], 32'h12345678);
        txn(0, 1'b0, 1'b0, 9'h1FF, 9'h1FF, '0, en_c, ack_c, wait_c, other);
        chk("t2_read_ack_cycle", ack_c, 2);
        chk("t2_a_rdata", ard_o[0], 32'h12345678);
        chk("t2_b_rdata", brd_o[0], 0);

        // Both ports request continuously after reset: strict alternation
        do_reset();
        a_we_v[0] = 0; a_addr_v[0] = 9'h010;
        b_we_v[0] = 0; b_addr_v[0] = 9'h1FF;
        a_req_v[0] = 1; b_req_v[0] = 1;
        acks_seen = 0;
        for (int n = 0; n < 60 && acks_seen < 6; n++) begin
            @(negedge clk);
            if (a_ack_o[0] || b_ack_o[0]) begin
                chk("t3_ack_overlap", a_ack_o[0] && b_ack_o[0], 0);
                ord_q.push_back(b_ack_o[0]);
                acks_seen++;
            end
        end
        @(posedge clk); #1;
        a_req_v[0] = 0; b_req_v[0] = 0;
        chk("t3_ack_count", acks_seen, 6);
        exp_ord = 6'b10_1010;
        for (int i = 0; i < 6 && i < ord_q.size(); i++)
            chk($sformatf("t3_grant_order_%0d", i), ord_q[i], exp_ord[i]);
        chk("t3_b_rdata", brd_o[0], 32'h12345678);

        // READ_LAT=3: WAIT length, ack cycle, address change ignored
        preload(1, 9'h020, 32'hCAFE0020);
        preload(1, 9'h030, 32'h0BAD0030);
        txn(1, 1'b0, 1'b0, 9'h020, 9'h030, '0, en_c, ack_c, wait_c, other);
        chk("t4_en_cycle", en_c, 1);
        chk("t4_wait_cycles", wait_c, 2);
        chk("t4_ack_cycle", ack_c, 4);
        chk("t4_a_rdata", ard_o[1], 32'hCAFE0020);
        repeat (3) @(negedge clk);
        chk("t4_a_rdata_hold", ard_o[1], 32'hCAFE0020);

        // Write with READ_LAT=3 still completes in two cycles
        txn(1, 1'b1, 1'b1, 9'h040, 9'h040, 32'h55AA55AA, en_c, ack_c, wait_c, other);
        chk("t4_write_ack_cycle", ack_c, 2);
        chk("t4_write_a_ack_seen", other, 0);

        // Reset in WAIT during a B read: everything clears at once, no ack
        @(posedge clk); #1;
        b_req_v[1] = 1; b_we_v[1] = 0; b_addr_v[1] = 9'h030;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_in_wait_busy", busy_o[1], 1);
        rst = 1'b1;
        b_req_v[1] = 0;
        #1;
        chk_rst_now(1);
        @(posedge clk); #1;
        rst = 1'b0;
        acks_seen = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (b_ack_o[1]) acks_seen++;
        end
        chk("t5_b_ack_after_abort", acks_seen, 0);
        txn(1, 1'b0, 1'b0, 9'h020, 9'h020, '0, en_c, ack_c, wait_c, other);
        chk("t5_recover_ack_cycle", ack_c, 4);
        chk("t5_recover_a_rdata", ard_o[1], 32'hCAFE0020);
        chk("t5_recover_grant_b", gb_o[1], 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port synchronous RAM behind MAR/MDR. Port A is the CPU memory path, driven by the control unit's Read/Write. Port B is the program-loader/debug path. The block grants the RAM to one requester at a time with round-robin fairness and sequences each transaction (issue, wait out read latency, capture, acknowledge). It returns data and a one-cycle acknowledge to the granted port.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 32, data width
READ_LAT, 1, cycles from the mem_en edge to valid mem_rdata; legal values 1..4

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
a_req  in  1  port A request; held until a_ack
a_we  in  1  port A write (1) / read (0)
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  port A one-cycle completion pulse
a_rdata  out  DATA_W  port A read data, valid from a_ack onward
b_req  in  1  port B request
b_we  in  1  port B write/read
b_addr  in  ADDR_W  port B address
b_wdata  in  DATA_W  port B write data
b_ack  out  1  port B completion pulse
b_rdata  out  DATA_W  port B read data
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data
busy  out  1  high in every state except IDLE
grant_b  out  1  0 = current/last grant to A, 1 = to B

Behaviour:
- Reset (async, immediate): state=IDLE. mem_en, mem_we, a_ack, b_ack, busy = 0. mem_addr, mem_wdata, a_rdata, b_rdata = 0. last_grant=B, so A wins the first tie. grant_b=1, reflecting last_grant. Latency counter = 0.
- All outputs are registered; mem_* are driven from captured registers, never combinationally from the a_/b_ inputs.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Only one req high -> grant that port.
  - Both high -> grant the port that is not last_grant.
  - At the grant edge: capture we/addr/wdata, set last_grant and grant_b, go to ISSUE.
  - No req -> stay in IDLE.
- ISSUE (exactly one cycle): mem_en=1, mem_we=captured we, mem_addr/mem_wdata from the capture.
  - Write -> DONE.
  - Read with READ_LAT=1 -> DONE.
  - Read with READ_LAT>1 -> WAIT, counter loaded with READ_LAT-1.
- WAIT: mem_en=0, mem_we=0. Counter decrements each cycle; -> DONE when it reaches 1.
- Read data capture: on the edge entering DONE, mem_rdata is latched into the granted port's rdata. The other port's rdata is unchanged.
- DONE (one cycle): granted port's ack=1 -> IDLE next edge. rdata holds until that port's next read ack; a write never changes rdata.
- Latency, with cycle 0 = IDLE cycle in which req is sampled:
  - write: mem_en in cycle 1, ack in cycle 2;
  - read: mem_en in cycle 1, ack in cycle READ_LAT+1;
  - next arbitration in cycle ack+1.
- Requester contract: hold req and payload stable until ack, and deassert req the cycle after ack. A req still high in the IDLE cycle after ack is treated as a new request. Payload changes during a transaction are ignored, since the payload was captured at grant.
- Fairness: with both ports continuously requesting, grants alternate strictly A,B,A,B. A single requester is granted back-to-back, one transaction per 3 cycles for writes and per READ_LAT+2 cycles for reads.
- Simultaneous events: a request arriving while busy waits for IDLE. Only one ack is ever asserted per cycle.
- Reset mid-transaction: the transaction is aborted with no ack. A RAM write already issued in ISSUE may have completed; this is acceptable. Arbitration restarts from the reset values.
- Addresses wrap naturally at ADDR_W; no range checking.

Test Plan:
- READ_LAT=1; RAM[0x010]=0xDEADBEEF; A read 0x010 -> mem_en cycle 1 with mem_addr=0x010, a_ack cycle 2, a_rdata=0xDEADBEEF, b_ack stays 0.
- B writes 0x12345678 to 0x1FF, then A reads 0x1FF -> RAM holds 0x12345678, a_rdata=0x12345678, b_rdata unchanged at 0.
- After reset, both ports request reads continuously for 6 transactions -> grant order A,B,A,B,A,B; grant_b toggles; acks never overlap.
- READ_LAT=3; A read -> WAIT for exactly 2 cycles, a_ack in cycle 4. A mem_rdata change after the capture edge does not alter a_rdata.
- Reset asserted in WAIT during a B read -> all outputs 0 immediately, no b_ack. A single A request afterwards completes normally.
- A changes a_addr from 0x020 to 0x030 during WAIT -> the access and the returned data are for 0x020.
